oa22_stim_gen: RTL and testbench

- Stimulus and response stage wrapped around the OA22X1 cell for power and functional characterization runs.
- Drives the cell inputs IN1..IN4 from registered outputs, one new vector per clock.
- Samples the cell output Q through input Q_FB and counts high samples and output toggles over a run of LEN vectors.
- The cell is the only logic between this block's IN* outputs and its Q_FB input.

---
 rtl/oa22_stim_gen.sv | 163 ++++++++++++++++
 tb/tb_oa22_stim_gen.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/oa22_stim_gen.sv
// Stimulus/response stage around an OA22X1 cell: drives IN1..IN4 from a registered vector
// and counts high samples and toggles of the cell output over a run of LEN vectors.
module oa22_stim_gen #(
   parameter logic [7:0]  SEED  = 8'hA5,
   parameter int unsigned LEN_W = 16
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             START,
   input  logic             MODE,
   input  logic [LEN_W-1:0] LEN,
   input  logic             Q_FB,
   output logic             IN1,
   output logic             IN2,
   output logic             IN3,
   output logic             IN4,
   output logic             BUSY,
   output logic             DONE,
   output logic [LEN_W-1:0] ONES,
   output logic [LEN_W-1:0] TOGGLES
);

   typedef enum logic [1:0] {
      StIdle,
      StRun,
      StDone
   } state_e;

   // An all-zero LFSR would lock up, so a zero seed is replaced by 1.
   localparam logic [7:0]       SeedEff = (SEED == 8'h00) ? 8'h01 : SEED;
   localparam logic [LEN_W-1:0] One     = {{(LEN_W-1){1'b0}}, 1'b1};
   localparam logic [LEN_W-1:0] Zero    = '0;

   state_e           state_q, state_d;
   logic [3:0]       vec_q, vec_d;
   logic [7:0]       lfsr_q, lfsr_d;
   logic [7:0]       lfsr_adv;
   logic             mode_q, mode_d;
   logic [LEN_W-1:0] len_q, len_d;
   logic [LEN_W-1:0] cnt_q, cnt_d;
   logic [LEN_W-1:0] ones_q, ones_d;
   logic [LEN_W-1:0] toggles_q, toggles_d;
   logic             prev_q, prev_d;
   logic             prev_valid_q, prev_valid_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   // Fibonacci LFSR, x^8+x^6+x^5+x^4+1, shifting left with feedback into bit 0.
   assign lfsr_adv = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

   always_comb begin
      state_d      = state_q;
      vec_d        = vec_q;
      lfsr_d       = lfsr_q;
      mode_d       = mode_q;
      len_d        = len_q;
      cnt_d        = cnt_q;
      ones_d       = ones_q;
      toggles_d    = toggles_q;
      prev_d       = prev_q;
      prev_valid_d = prev_valid_q;
      busy_d       = 1'b0;
      done_d       = 1'b0;

      unique case (state_q)
         StIdle: begin
            vec_d = 4'd0;
            if (START) begin
               mode_d       = MODE;
               len_d        = LEN;
               ones_d       = Zero;
               toggles_d    = Zero;
               prev_valid_d = 1'b0;
               cnt_d        = Zero;
               lfsr_d       = SeedEff;
               if (LEN == Zero) begin
                  state_d = StDone;
                  done_d  = 1'b1;
               end else begin
                  state_d = StRun;
                  busy_d  = 1'b1;
                  vec_d   = MODE ? SeedEff[3:0] : 4'd0;
               end
            end
         end

         StRun: begin
            busy_d = 1'b1;
            if (Q_FB) begin
               ones_d = ones_q + One;
            end
            if (prev_valid_q && (prev_q != Q_FB)) begin
               toggles_d = toggles_q + One;
            end
            prev_d       = Q_FB;
            prev_valid_d = 1'b1;
            cnt_d        = cnt_q + One;
            if (mode_q) begin
               lfsr_d = lfsr_adv;
               vec_d  = lfsr_adv[3:0];
            end else begin
               vec_d = vec_q + 4'd1;
            end
            if (cnt_d == len_q) begin
               state_d = StDone;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               vec_d   = 4'd0;
            end
         end

         StDone: begin
            state_d = StIdle;
            vec_d   = 4'd0;
         end

         default: begin
            state_d = StIdle;
            vec_d   = 4'd0;
         end
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q      <= StIdle;
         vec_q        <= 4'd0;
         lfsr_q       <= SeedEff;
         mode_q       <= 1'b0;
         len_q        <= Zero;
         cnt_q        <= Zero;
         ones_q       <= Zero;
         toggles_q    <= Zero;
         prev_q       <= 1'b0;
         prev_valid_q <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         vec_q        <= vec_d;
         lfsr_q       <= lfsr_d;
         mode_q       <= mode_d;
         len_q        <= len_d;
         cnt_q        <= cnt_d;
         ones_q       <= ones_d;
         toggles_q    <= toggles_d;
         prev_q       <= prev_d;
         prev_valid_q <= prev_valid_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
      end
   end

   assign IN1     = vec_q[0];
   assign IN2     = vec_q[1];
   assign IN3     = vec_q[2];
   assign IN4     = vec_q[3];
   assign BUSY    = busy_q;
   assign DONE    = done_q;
   assign ONES    = ones_q;
   assign TOGGLES = toggles_q;

endmodule

// File: tb/tb_oa22_stim_gen.sv
// Directed bench for oa22_stim_gen with a behavioural OA22 cell closing the loop to Q_FB.
module tb_oa22_stim_gen;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        mode;
   logic [15:0] len;
   logic        q_fb;
   logic        in1, in2, in3, in4;
   logic        busy, done;
   logic [15:0] ones, toggles;

   int checks = 0;
   int errors = 0;
   int m_ones, m_tog;

   always #5 clk = ~clk;

   // The OA22X1 cell under characterization.
   assign q_fb = (in1 | in2) & (in3 | in4);

   oa22_stim_gen #(
      .SEED  (8'hA5),
      .LEN_W (16)
   ) dut (
      .CLK     (clk),
      .RST     (rst),
      .START   (start),
      .MODE    (mode),
      .LEN     (len),
      .Q_FB    (q_fb),
      .IN1     (in1),
      .IN2     (in2),
      .IN3     (in3),
      .IN4     (in4),
      .BUSY    (busy),
      .DONE    (done),
      .ONES    (ones),
      .TOGGLES (toggles)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] lfsr_step(input logic [7:0] s);
      return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
   endfunction

   // Runs one START..DONE sequence, checking every RUN cycle against a golden model.
   // With perturb set, START/MODE/LEN are disturbed mid-run and must have no effect.
   task automatic do_run(input logic m, input logic [15:0] n, input bit perturb,
                         output int o_ones, output int o_tog);
      logic [7:0] lf;
      logic [3:0] v;
      logic       q, prev;
      bit         pv;
      int         om, tm;
      om = 0;
      tm = 0;
      pv = 0;
      prev = 1'b0;
      @(negedge clk);
      mode  = m;
      len   = n;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      lf = 8'hA5;
      v  = m ? lf[3:0] : 4'd0;
      for (int i = 0; i < int'(n); i++) begin
         if (perturb && i == 2) begin
            start = 1'b1;
            mode  = ~m;
            len   = 16'd3;
         end
         if (perturb && i == 3) start = 1'b0;
         check("busy_run", {31'd0, busy}, 32'd1);
         check("done_run", {31'd0, done}, 32'd0);
         check("vec", {28'd0, in4, in3, in2, in1}, {28'd0, v});
         q = (v[0] | v[1]) & (v[2] | v[3]);
         if (q) om++;
         if (pv && q != prev) tm++;
         prev = q;
         pv   = 1;
         if (m) begin
            lf = lfsr_step(lf);
            v  = lf[3:0];
         end else begin
            v = v + 4'd1;
         end
         @(negedge clk);
      end
      start = 1'b0;
      check("done_pulse", {31'd0, done}, 32'd1);
      check("busy_done", {31'd0, busy}, 32'd0);
      check("vec_done", {28'd0, in4, in3, in2, in1}, 32'd0);
      check("ones_model", {16'd0, ones}, om);
      check("toggles_model", {16'd0, toggles}, tm);
      @(negedge clk);
      check("done_single", {31'd0, done}, 32'd0);
      check("busy_idle", {31'd0, busy}, 32'd0);
      mode = 1'b0;
      len  = 16'd0;
      o_ones = om;
      o_tog  = tm;
   endtask

   initial begin
      rst   = 1'b1;
      start = 1'b0;
      mode  = 1'b0;
      len   = 16'd0;
      repeat (2) @(negedge clk);
      check("rst_vec", {28'd0, in4, in3, in2, in1}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_ones", {16'd0, ones}, 32'd0);
      check("rst_toggles", {16'd0, toggles}, 32'd0);
      rst = 1'b0;

      // Exhaustive 16 vectors: OA22 is high on 9 of them with 5 changes.
      do_run(1'b0, 16'd16, 1'b0, m_ones, m_tog);
      check("ones_16", {16'd0, ones}, 32'd9);
      check("toggles_16", {16'd0, toggles}, 32'd5);

      // Wrap 15->0 adds a 1->0 change.
      do_run(1'b0, 16'd32, 1'b0, m_ones, m_tog);
      check("ones_32", {16'd0, ones}, 32'd18);
      check("toggles_32", {16'd0, toggles}, 32'd11);

      // Zero-length run: DONE straight after START, counters cleared.
      do_run(1'b0, 16'd0, 1'b0, m_ones, m_tog);
      check("ones_len0", {16'd0, ones}, 32'd0);
      check("toggles_len0", {16'd0, toggles}, 32'd0);

      // LFSR vectors from seed A5: first vectors are 5, A, 5, A.
      do_run(1'b1, 16'd20, 1'b0, m_ones, m_tog);
      check("ones_lfsr_held", {16'd0, ones}, m_ones);

      // Mid-run disturbances must not change length or results.
      do_run(1'b0, 16'd16, 1'b1, m_ones, m_tog);
      check("ones_perturb", {16'd0, ones}, 32'd9);
      check("toggles_perturb", {16'd0, toggles}, 32'd5);
      do_run(1'b1, 16'd20, 1'b1, m_ones, m_tog);

      // Asynchronous reset during RUN cycle 7.
      @(negedge clk);
      mode  = 1'b0;
      len   = 16'd16;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (6) @(negedge clk);
      check("pre_rst_vec", {28'd0, in4, in3, in2, in1}, 32'd6);
      check("pre_rst_ones", {16'd0, ones}, 32'd1);
      check("pre_rst_toggles", {16'd0, toggles}, 32'd1);
      #3 rst = 1'b1;
      #1;
      check("arst_vec", {28'd0, in4, in3, in2, in1}, 32'd0);
      check("arst_busy", {31'd0, busy}, 32'd0);
      check("arst_done", {31'd0, done}, 32'd0);
      check("arst_ones", {16'd0, ones}, 32'd0);
      check("arst_toggles", {16'd0, toggles}, 32'd0);
      rst = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         check("post_rst_done", {31'd0, done}, 32'd0);
         check("post_rst_busy", {31'd0, busy}, 32'd0);
      end
      do_run(1'b0, 16'd16, 1'b0, m_ones, m_tog);
      check("ones_after_rst", {16'd0, ones}, 32'd9);
      check("toggles_after_rst", {16'd0, toggles}, 32'd5);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
